// File: rtl/tag_dispatcher.sv
// tag_dispatcher: credit-based, packet-granular tag scheduler for one crossbar
// input port. Each packet is given a destination tag picked round-robin among
// outputs that hold credits; the tag is held for every beat through `last`.
// Optional macro TAG_DISPATCH_STATS_EN enables the 32-bit dispatched-packet
// counter on pkt_count; without it pkt_count is tied to zero.
module tag_dispatcher #(
  parameter int DATA_WIDTH  = 512,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int NUM_OUTPUTS = 4,
  parameter int TAG_WIDTH   = $clog2(NUM_OUTPUTS),
  parameter int MAX_CREDITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [KEEP_WIDTH-1:0]  in_keep,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [KEEP_WIDTH-1:0]  out_keep,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [NUM_OUTPUTS-1:0] credit_return,
  output logic                   credit_err,
  output logic [31:0]            pkt_count
);

  localparam int CW  = $clog2(MAX_CREDITS + 1);
  localparam int TW1 = TAG_WIDTH + 1;
  localparam logic [CW-1:0]        CMAX     = CW'(MAX_CREDITS);
  localparam logic [CW-1:0]        CONE     = CW'(1);
  localparam logic [TAG_WIDTH-1:0] LAST_IDX = TAG_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [TAG_WIDTH-1:0] TONE     = TAG_WIDTH'(1);
  localparam logic [TW1-1:0]       N_EXT    = TW1'(NUM_OUTPUTS);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                 r_state;
  logic [TAG_WIDTH-1:0]   r_lock;
  logic [TAG_WIDTH-1:0]   r_rr_ptr;

  logic                   r_out_valid;
  logic                   r_out_last;
  logic [TAG_WIDTH-1:0]   r_out_tag;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [KEEP_WIDTH-1:0]  r_out_keep;
  logic                   r_credit_err;

  logic [NUM_OUTPUTS-1:0] w_has_credit;
  logic [NUM_OUTPUTS-1:0] w_consume;
  logic [NUM_OUTPUTS-1:0] w_err_set;
  logic                   w_sel_found;
  logic [TAG_WIDTH-1:0]   w_sel;
  logic [TW1-1:0]         w_scan_sum;
  logic [TAG_WIDTH-1:0]   w_scan_idx;
  logic                   w_can_issue;
  logic                   w_ld;
  logic                   w_accept;
  logic [TAG_WIDTH-1:0]   w_tag;

  // Round-robin pick: first output with credit, scanning upward from r_rr_ptr.
  always_comb begin
    w_sel       = '0;
    w_sel_found = 1'b0;
    w_scan_sum  = '0;
    w_scan_idx  = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      w_scan_sum = {1'b0, r_rr_ptr} + TW1'(k);
      if (w_scan_sum >= N_EXT) begin
        w_scan_sum = w_scan_sum - N_EXT;
      end
      w_scan_idx = w_scan_sum[TAG_WIDTH-1:0];
      if (!w_sel_found && w_has_credit[w_scan_idx]) begin
        w_sel_found = 1'b1;
        w_sel       = w_scan_idx;
      end
    end
  end

  // An open packet may only advance while its locked output still has credit.
  assign w_can_issue = (r_state == S_IDLE) ? w_sel_found : w_has_credit[r_lock];
  assign w_ld        = !r_out_valid || out_ready;
  assign in_ready    = w_ld && w_can_issue;
  assign w_accept    = in_valid && in_ready;
  assign w_tag       = (r_state == S_IDLE) ? w_sel : r_lock;

  // Per-output credit pools: +1 on return, -1 on consume, saturate at full.
  for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_credit
    logic [CW-1:0] r_cnt;

    assign w_has_credit[gi] = (r_cnt != '0);
    assign w_consume[gi]    = w_accept && (w_tag == TAG_WIDTH'(gi));
    assign w_err_set[gi]    = credit_return[gi] && !w_consume[gi] && (r_cnt == CMAX);

    // Credit counter update for this output.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= CMAX;
      end else if (credit_return[gi] && !w_consume[gi] && (r_cnt != CMAX)) begin
        r_cnt <= r_cnt + CONE;
      end else if (w_consume[gi] && !credit_return[gi]) begin
        r_cnt <= r_cnt - CONE;
      end
    end
  end

  // Sticky flag for a credit returned into an already-full pool.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit_err <= 1'b0;
    end else if (|w_err_set) begin
      r_credit_err <= 1'b1;
    end
  end

  // Packet FSM: picks and locks a destination on the first beat of a packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lock   <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          r_rr_ptr <= (w_sel == LAST_IDX) ? '0 : (w_sel + TONE);
          if (!in_last) begin
            r_state <= S_BUSY;
            r_lock  <= w_sel;
          end
        end
        S_BUSY: begin
          if (in_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output stage control: valid/tag/last loaded whenever the stage can take a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_ld) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_tag  <= w_tag;
        r_out_last <= in_last;
      end
    end
  end

  // Payload register; contents are don't-care while out_valid is low.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_out_data <= in_data;
      r_out_keep <= in_keep;
    end
  end

`ifdef TAG_DISPATCH_STATS_EN
  logic [31:0] r_pkt_count;

  // Count dispatched packets (accepted last beats); wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
    end else if (w_accept && in_last) begin
      r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign pkt_count = r_pkt_count;
`else
  assign pkt_count = '0;
`endif

  assign out_valid  = r_out_valid;
  assign out_tag    = r_out_tag;
  assign out_last   = r_out_last;
  assign out_data   = r_out_data;
  assign out_keep   = r_out_keep;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_tag_dispatcher.sv
// Directed testbench for tag_dispatcher (NUM_OUTPUTS=4, MAX_CREDITS=16).
module tb_tag_dispatcher;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int NO = 4;
  localparam int TW = 2;
`ifdef TAG_DISPATCH_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [KW-1:0] in_keep = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic [KW-1:0] out_keep;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NO-1:0] credit_return = '0;
  logic          credit_err;
  logic [31:0]   pkt_count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tag_dispatcher #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_OUTPUTS(NO), .TAG_WIDTH(TW), .MAX_CREDITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_tag(out_tag), .out_keep(out_keep),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .credit_return(credit_return), .credit_err(credit_err), .pkt_count(pkt_count)
  );

  // Drive one beat; returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit done;
    done = 1'b0;
    in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (in_ready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++; n_miss++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles (data %08h)", d);
    end else begin
      $display("beat data=%08h keep=%h last=%0d", d, k, l);
    end
  endtask

  task automatic pulse_return(input logic [NO-1:0] m);
    credit_return = m;
    @(posedge clk); #1;
    credit_return = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; credit_return = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_tag !== 2'd0) begin n_miss++; $display("FAIL rst_out_tag: got %0d want 0", out_tag); end
    n_vec++; if (out_last !== 1'b0) begin n_miss++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    n_vec++; if (credit_err !== 1'b0) begin n_miss++; $display("FAIL rst_credit_err: got %b want 0", credit_err); end
    n_vec++; if (pkt_count !== 32'd0) begin n_miss++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_round_robin();
    logic [KW-1:0] k;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      k = (i == 5) ? 4'h0 : 4'hF;
      send_beat(32'hA000_0000 + i, k, 1'b1);
      n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL rr_valid[%0d]: got %b want 1", i, out_valid); end
      n_vec++; if (out_tag !== TW'(i % 4)) begin n_miss++; $display("FAIL rr_tag[%0d]: got %0d want %0d", i, out_tag, i % 4); end
      n_vec++; if (out_data !== 32'hA000_0000 + i) begin n_miss++; $display("FAIL rr_data[%0d]: got %08h want %08h", i, out_data, 32'hA000_0000 + i); end
      n_vec++; if (out_keep !== k) begin n_miss++; $display("FAIL rr_keep[%0d]: got %h want %h", i, out_keep, k); end
      n_vec++; if (out_last !== 1'b1) begin n_miss++; $display("FAIL rr_last[%0d]: got %b want 1", i, out_last); end
    end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rr_idle_valid: got %b want 0", out_valid); end
    n_vec++; if (pkt_count !== 32'(STATS * 8)) begin n_miss++; $display("FAIL rr_pkt_count: got %0d want %0d", pkt_count, STATS * 8); end
    // Output 0 should now hold exactly 14 credits.
    for (int i = 0; i < 14; i++) begin
      send_beat(32'hB000_0000 + i, 4'hF, 1'b0);
      n_vec++; if (out_tag !== 2'd0) begin n_miss++; $display("FAIL rr14_tag[%0d]: got %0d want 0", i, out_tag); end
    end
    in_data = 32'hB0FF_FFFF; in_valid = 1'b1; #1;
    n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL rr14_stall: in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_no_reroute();
    do_reset();
    for (int i = 0; i < 13; i++) send_beat(32'hC000_0000 + i, 4'hF, (i == 12));
    n_vec++; if (out_tag !== 2'd0) begin n_miss++; $display("FAIL hol_fill_tag: got %0d want 0", out_tag); end
    for (int i = 1; i < 4; i++) begin
      send_beat(32'hC100_0000 + i, 4'hF, 1'b1);
      n_vec++; if (out_tag !== TW'(i)) begin n_miss++; $display("FAIL hol_single_tag[%0d]: got %0d want %0d", i, out_tag, i); end
    end
    pulse_return(4'b1110);
    for (int i = 0; i < 3; i++) begin
      send_beat(32'hD000_0000 + i, 4'hF, 1'b0);
      n_vec++; if (out_tag !== 2'd0) begin n_miss++; $display("FAIL hol_beat_tag[%0d]: got %0d want 0", i + 1, out_tag); end
    end
    for (int b = 3; b < 5; b++) begin
      in_data = 32'hD000_0000 + b; in_keep = 4'hF; in_last = (b == 4); in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL hol_stall[%0d]: in_ready got %b want 0", b + 1, in_ready); end
        @(posedge clk); #1;
      end
      credit_return = 4'b0001; #1;
      n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL hol_pulse_cycle[%0d]: in_ready got %b want 0", b + 1, in_ready); end
      @(posedge clk); #1;
      credit_return = '0;
      send_beat(32'hD000_0000 + b, 4'hF, (b == 4));
      n_vec++; if (out_tag !== 2'd0) begin n_miss++; $display("FAIL hol_beat_tag[%0d]: got %0d want 0", b + 1, out_tag); end
      n_vec++; if (out_data !== 32'hD000_0000 + b) begin n_miss++; $display("FAIL hol_beat_data[%0d]: got %08h want %08h", b + 1, out_data, 32'hD000_0000 + b); end
    end
    n_vec++; if (out_last !== 1'b1) begin n_miss++; $display("FAIL hol_last: got %b want 1", out_last); end
    send_beat(32'hD100_0000, 4'hF, 1'b1);
    n_vec++; if (out_tag !== 2'd1) begin n_miss++; $display("FAIL hol_next_tag: got %0d want 1", out_tag); end
  endtask

  task automatic test_skip_empty();
    logic [TW-1:0] exp_tag [5];
    exp_tag[0] = 2'd2; exp_tag[1] = 2'd3; exp_tag[2] = 2'd0; exp_tag[3] = 2'd2; exp_tag[4] = 2'd3;
    do_reset();
    send_beat(32'hE000_0000, 4'hF, 1'b1);
    for (int i = 0; i < 16; i++) send_beat(32'hE100_0000 + i, 4'hF, (i == 15));
    n_vec++; if (out_tag !== 2'd1) begin n_miss++; $display("FAIL skip_drain_tag: got %0d want 1", out_tag); end
    for (int i = 0; i < 5; i++) begin
      send_beat(32'hE200_0000 + i, 4'hF, 1'b1);
      n_vec++; if (out_tag !== exp_tag[i]) begin n_miss++; $display("FAIL skip_tag[%0d]: got %0d want %0d", i, out_tag, exp_tag[i]); end
    end
  endtask

  task automatic test_credits();
    do_reset();
    for (int i = 0; i < 3; i++) send_beat(32'hF000_0000 + i, 4'hF, 1'b1);
    credit_return = 4'b1000;
    send_beat(32'hF100_0000, 4'hF, 1'b0);
    credit_return = '0;
    n_vec++; if (out_tag !== 2'd3) begin n_miss++; $display("FAIL simul_tag: got %0d want 3", out_tag); end
    for (int i = 1; i <= 16; i++) send_beat(32'hF100_0000 + i, 4'hF, 1'b0);
    n_vec++; if (out_tag !== 2'd3) begin n_miss++; $display("FAIL simul_tail_tag: got %0d want 3", out_tag); end
    in_valid = 1'b1; #1;
    n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL simul_stall: in_ready got %b want 0", in_ready); end
    n_vec++; if (credit_err !== 1'b0) begin n_miss++; $display("FAIL simul_no_err: credit_err got %b want 0", credit_err); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    pulse_return(4'b1000);
    send_beat(32'hF1FF_FFFF, 4'hF, 1'b1);
    pulse_return(4'b0100);
    n_vec++; if (credit_err !== 1'b0) begin n_miss++; $display("FAIL err_refill: credit_err got %b want 0", credit_err); end
    pulse_return(4'b0100);
    n_vec++; if (credit_err !== 1'b1) begin n_miss++; $display("FAIL err_set: credit_err got %b want 1", credit_err); end
    repeat (3) @(posedge clk); #1;
    n_vec++; if (credit_err !== 1'b1) begin n_miss++; $display("FAIL err_sticky: credit_err got %b want 1", credit_err); end
    send_beat(32'hF200_0000, 4'hF, 1'b1);
    send_beat(32'hF200_0001, 4'hF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send_beat(32'hF300_0000 + i, 4'hF, 1'b0);
      n_vec++; if (out_tag !== 2'd2) begin n_miss++; $display("FAIL sat_tag[%0d]: got %0d want 2", i, out_tag); end
    end
    in_valid = 1'b1; #1;
    n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL sat_stall: in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    send_beat(32'h1111_0001, 4'hF, 1'b0);
    out_ready = 1'b0;
    in_data = 32'h1111_0002; in_keep = 4'hF; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
      n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
      n_vec++; if (out_data !== 32'h1111_0001) begin n_miss++; $display("FAIL bp_data[%0d]: got %08h want 11110001", c, out_data); end
      n_vec++; if (out_tag !== 2'd0) begin n_miss++; $display("FAIL bp_tag[%0d]: got %0d want 0", c, out_tag); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_beat(32'h1111_0002, 4'hF, 1'b0);
    n_vec++; if (out_data !== 32'h1111_0002) begin n_miss++; $display("FAIL bp_resume_data: got %08h want 11110002", out_data); end
    send_beat(32'h1111_0003, 4'hF, 1'b1);
    n_vec++; if (out_data !== 32'h1111_0003) begin n_miss++; $display("FAIL bp_last_data: got %08h want 11110003", out_data); end
    n_vec++; if (out_tag !== 2'd0 || out_last !== 1'b1) begin n_miss++; $display("FAIL bp_last_tag: got tag %0d last %b want tag 0 last 1", out_tag, out_last); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL bp_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_beat(32'h2222_0001, 4'hF, 1'b0);
    n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
    in_data = 32'h2222_0002; in_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL ar_async_valid: got %b want 0", out_valid); end
    in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_beat(32'h3333_0000 + i, 4'hF, 1'b1);
      n_vec++; if (out_tag !== TW'(i)) begin n_miss++; $display("FAIL ar_tag[%0d]: got %0d want %0d", i, out_tag, i); end
    end
    n_vec++; if (pkt_count !== 32'(STATS * 3)) begin n_miss++; $display("FAIL ar_pkt_count: got %0d want %0d", pkt_count, STATS * 3); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_no_reroute();
    test_skip_empty();
    test_credits();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
